// File: rtl/bitwise_pkg.sv
// ============================================================================
// Module   : bitwise_pkg
// Brief    : Operation encoding shared by the bit-wise logic unit and its core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitwise_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_XNOR   = 3'd3,
        OP_NAND   = 3'd4,
        OP_NOR    = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

endpackage : bitwise_pkg

`default_nettype wire

// File: rtl/bitwise_logic_core.sv
// ============================================================================
// Module   : bitwise_logic_core
// Brief    : Combinational per-bit operation select with all-zeros/all-ones flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitwise_logic_core
    import bitwise_pkg::*;
#(
    parameter int N = 8
) (
    input  op_e          op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] f,
    output logic         zero,
    output logic         ones
);

    always_comb begin
        f = a;
        case (op)
            OP_AND:    f = a & b;
            OP_OR:     f = a | b;
            OP_XOR:    f = a ^ b;
            OP_XNOR:   f = ~(a ^ b);
            OP_NAND:   f = ~(a & b);
            OP_NOR:    f = ~(a | b);
            OP_NOT_A:  f = ~a;
            OP_PASS_A: f = a;
            default:   f = a;
        endcase
    end

    assign zero = (f == '0);
    assign ones = (f == '1);

endmodule : bitwise_logic_core

`default_nettype wire

// File: rtl/pipelined_bitwise_logic_unit.sv
// ============================================================================
// Module   : pipelined_bitwise_logic_unit
// Brief    : STAGES-deep registered bit-wise logic unit with valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_bitwise_logic_unit
    import bitwise_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    c,
    output logic            zero,
    output logic            ones
);

    logic [N-1:0] w_f;
    logic         w_f_zero;
    logic         w_f_ones;
    logic         w_advance;

    logic [N-1:0] w_data_q  [STAGES];
    logic         w_valid_q [STAGES];
    logic         w_zero_q  [STAGES];
    logic         w_ones_q  [STAGES];

    bitwise_logic_core #(
        .N (N)
    ) u_core (
        .op   (op_e'(op)),
        .a    (a),
        .b    (b),
        .f    (w_f),
        .zero (w_f_zero),
        .ones (w_f_ones)
    );

    // The whole pipe moves as one; bubbles are never squeezed out.
    assign w_advance = out_ready | ~w_valid_q[STAGES-1];
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [N-1:0] r_data;
        logic         r_valid;
        logic         r_zero;
        logic         r_ones;
        logic [N-1:0] w_data_d;
        logic         w_valid_d;
        logic         w_zero_d;
        logic         w_ones_d;

        if (k == 0) begin : g_head
            assign w_data_d  = w_f;
            assign w_valid_d = in_valid & w_advance;
            assign w_zero_d  = w_f_zero;
            assign w_ones_d  = w_f_ones;
        end else begin : g_body
            assign w_data_d  = w_data_q[k-1];
            assign w_valid_d = w_valid_q[k-1];
            assign w_zero_d  = w_zero_q[k-1];
            assign w_ones_d  = w_ones_q[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_zero  <= 1'b0;
                r_ones  <= 1'b0;
            end else if (w_advance) begin
                r_data  <= w_data_d;
                r_valid <= w_valid_d;
                r_zero  <= w_zero_d;
                r_ones  <= w_ones_d;
            end
        end

        assign w_data_q[k]  = r_data;
        assign w_valid_q[k] = r_valid;
        assign w_zero_q[k]  = r_zero;
        assign w_ones_q[k]  = r_ones;
    end

    assign out_valid = w_valid_q[STAGES-1];
    assign c         = w_data_q[STAGES-1];
    assign zero      = w_zero_q[STAGES-1];
    assign ones      = w_ones_q[STAGES-1];

endmodule : pipelined_bitwise_logic_unit

`default_nettype wire

// File: tb/tb_pipelined_bitwise_logic_unit.sv
// ============================================================================
// Module   : tb_pipelined_bitwise_logic_unit
// Brief    : Self-checking bench: vector table, corner sequences, random stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_bitwise_logic_unit;

    localparam int N      = 8;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         zero;
    logic         ones;

    pipelined_bitwise_logic_unit #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zero      (zero),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_c;
        logic         exp_zero;
        logic         exp_ones;
    } vec_t;

    typedef struct {
        logic [N-1:0] c;
        logic         zero;
        logic         ones;
        int           edge_no;
    } sb_t;

    sb_t          q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           edge_cnt = 0;
    logic [N-1:0] t_exp_c;
    logic         t_exp_zero;
    logic         t_exp_ones;

    // Reference: each op is a 4-entry truth table indexed by {a[i], b[i]}.
    function automatic logic [N-1:0] model(input logic [2:0] f_op, input logic [N-1:0] f_a,
                                           input logic [N-1:0] f_b);
        logic [3:0]   tt;
        logic [N-1:0] r;
        case (f_op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b1001;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < N; i++) r[i] = tt[{f_a[i], f_b[i]}];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic set_model_exp();
        t_exp_c    = model(op, a, b);
        t_exp_zero = (t_exp_c == '0);
        t_exp_ones = (t_exp_c == '1);
    endtask

    // One clock: sample handshakes before the edge, score transfers, record accepts.
    task automatic cycle(input bit chk_lat);
        bit  acc;
        bit  xfer;
        sb_t e;
        #1;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_output: got c=0x%0h with nothing outstanding, expected no out_valid", c);
            end else begin
                e = q.pop_front();
                if (c !== e.c || zero !== e.zero || ones !== e.ones ||
                    (chk_lat && edge_cnt != e.edge_no + STAGES - 1))
                    $display("FAIL result: got c=0x%0h z=%0b o=%0b edge=%0d, expected c=0x%0h z=%0b o=%0b edge=%0d",
                             c, zero, ones, edge_cnt, e.c, e.zero, e.ones, e.edge_no + STAGES - 1);
                else n_pass++;
            end
        end
        @(posedge clk);
        edge_cnt++;
        if (acc) begin
            e.c = t_exp_c; e.zero = t_exp_zero; e.ones = t_exp_ones; e.edge_no = edge_cnt;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0);
        chk("drain_outstanding", q.size(), 0);
        #1;
        chk("drain_out_valid", out_valid, 1'b0);
    endtask

    task automatic send_random(input int count);
        in_valid = 1'b1;
        for (int i = 0; i < count; i++) begin
            op = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
            set_model_exp();
            cycle(1'b0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'd0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
        vecs[1] = '{3'd1, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
        vecs[2] = '{3'd2, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
        vecs[3] = '{3'd3, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0};
        vecs[4] = '{3'd4, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
        vecs[5] = '{3'd5, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0};
        vecs[6] = '{3'd6, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{3'd7, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
        vecs[8] = '{3'd3, 8'h0F, 8'h0F, 8'hFF, 1'b0, 1'b1};
        vecs[9] = '{3'd2, 8'h0F, 8'h0F, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        t_exp_c = '0; t_exp_zero = 1'b0; t_exp_ones = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_c", c, 0);
        chk("reset_zero", zero, 1'b0);
        chk("reset_ones", ones, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Op sweep and flag vectors, back-to-back with latency checked.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            t_exp_c = vecs[i].exp_c; t_exp_zero = vecs[i].exp_zero; t_exp_ones = vecs[i].exp_ones;
            cycle(1'b1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4 && q.size() != 0; i++) cycle(1'b1);
        chk("sweep_outstanding", q.size(), 0);

        // Backpressure: fill, stall 5 cycles with in_valid still asserted, then drain.
        out_ready = 1'b0;
        send_random(2);
        for (int i = 0; i < 5; i++) begin
            op = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
            set_model_exp();
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_c_held", c, q[0].c);
            cycle(1'b0);
        end
        drain();

        // Full pipe with simultaneous drain and accept: no bubble.
        out_ready = 1'b0;
        send_random(2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
            set_model_exp();
            #1;
            chk("simul_in_ready", in_ready, 1'b1);
            chk("simul_out_valid", out_valid, 1'b1);
            cycle(1'b0);
        end
        drain();

        // Reset with two transactions in flight.
        out_ready = 1'b1;
        send_random(2);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_c", c, 0);
        chk("midrst_in_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("postrst_out_valid", out_valid, 1'b0);
            cycle(1'b0);
        end

        // Random stream with random valid/ready against the reference model.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
            set_model_exp();
            cycle(1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipelined_bitwise_logic_unit

`default_nettype wire

// File: doc/pipelined_bitwise_logic_unit.md
Name: pipelined_bitwise_logic_unit

Overview:
- Parametrised, multi-operation bit-wise logic unit. It is the sequential successor to the fixed-function structural bit-wise gates.
- Selects one of eight bit-wise operations per transaction and registers the result through a STAGES-deep pipeline with a valid/ready handshake and backpressure.
- Emits all-zeros and all-ones flags alongside the result.
- Sits between upstream datapath producers and downstream consumers in BasicCombinationalLogic-based designs.

Parameters:
- N, 8: operand/result width in bits; N >= 1.
- STAGES, 2: pipeline register depth; STAGES >= 1.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst_n  input  1  Reset, asynchronous assert, active-low.
- in_valid  input  1  Upstream transaction valid.
- in_ready  output  1  Unit can accept this cycle.
- op  input  3  Operation select (op_e encoding).
- a  input  N  Operand A.
- b  input  N  Operand B; ignored by NOT_A and PASS_A.
- out_valid  output  1  Result valid.
- out_ready  input  1  Downstream accepts the result.
- c  output  N  Result.
- zero  output  1  High when c == 0.
- ones  output  1  High when c == all ones.

Behaviour:
- Reset, asserted while rst_n == 0, asynchronously:
  - All stage valid bits go to 0.
  - All stage data registers and flags go to 0.
  - Outputs: out_valid = 0, c = 0, zero = 0, ones = 0.
  - in_ready = 1 combinationally after reset, because the last stage is empty.
- Op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT_A, 7 PASS_A.
  - All operations are computed per bit; there is no carry or cross-bit interaction.
- Advance condition: advance = out_ready OR NOT v[STAGES-1].
  - in_ready = advance. This is a combinational path from out_ready and the last-stage valid bit.
- Accept: a transfer occurs when in_valid AND in_ready.
  - Stage 0 captures f(op, a, b), zero(f) and ones(f).
  - v[0] is set to (in_valid AND in_ready).
- On advance, every stage k > 0 loads stage k-1 (data, flags and valid). Without advance, all stages hold.
  - Bubbles are not collapsed: the whole pipe stalls when the last stage is full and out_ready is 0.
- Outputs out_valid, c, zero and ones come directly from the last stage register. There is no combinational path from a/b/op to the outputs.
- Latency: with out_ready held at 1, a result accepted at edge T is presented with out_valid = 1 after edge T+STAGES-1, so it is visible in the cycle following the STAGES-th edge. Throughput is one transaction per cycle.
- Stall stability: while out_valid = 1 and out_ready = 0, c, zero, ones and out_valid hold unchanged until the transfer completes.
- Data registers are loaded even when the incoming valid is 0. Their content is don't-care while the matching valid bit is 0, except after reset, when it is 0.
- Boundary conditions:
  - Simultaneous output transfer and input accept in the same cycle is legal; no bubble is inserted.
  - in_valid = 0 on an advance shifts a bubble in.
  - With N = 1, zero and ones are mutually exclusive and exactly one is high whenever out_valid = 1.
- Reset mid-operation: in-flight transactions are discarded and outputs return to reset values immediately. No transaction is presented after rst_n deasserts until a new accept occurs.

Decomposition:
- Package bitwise_pkg:
  - typedef enum logic [2:0] op_e: OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT_A, OP_PASS_A.
  - Constant OP_W = 3.
- Sub-module bitwise_logic_core #(N): purely combinational op/a/b -> f, zero, ones. It is instantiated once ahead of stage 0 and is reusable elsewhere.
- The top level holds the stage registers (generate loop over STAGES) and the handshake logic.

Test Plan (N = 8, STAGES = 2):
- Reset: hold rst_n = 0 mid-stream with 2 transactions in flight -> out_valid = 0, c = 0x00, in_ready = 1 immediately; no stale output appears after release.
- Op sweep: out_ready = 1, a = 0xA5, b = 0x3C, op = 0..7 back-to-back -> c = 0x24, 0xBD, 0x99, 0x66, 0xDB, 0x42, 0x5A, 0xA5 in order, each 2 cycles after accept, one per cycle.
- Flags: XNOR of a = 0x0F with b = 0x0F -> c = 0xFF, ones = 1, zero = 0. XOR of the same operands -> c = 0x00, zero = 1, ones = 0.
- Backpressure: fill both stages, then out_ready = 0 for 5 cycles -> in_ready = 0, c held constant. Release -> both results drain in order with none lost or duplicated.
- Simultaneous accept and drain: pipe full, out_ready = 1, in_valid = 1 -> in_ready = 1, output transfer and input accept in the same cycle, no bubble.
- Random stream: 10k random a/b/op with random in_valid/out_ready -> scoreboard matches the reference model exactly and in order.
